three_bit_count_pwm: RTL

Downstream consumer of the free-running 3-bit ripple up-counter. It resamples the counter's `Q[2:0]` into the local clock domain and checks that the sequence steps by +1 mod 8. It detects wrap-around (7→0), counts periods and produces a PWM output whose duty is loaded through a valid/ready handshake. New duty values take effect only at a period boundary.

---
 rtl/three_bit_count_pwm.sv | 89 ++++++++
 1 files changed

// File: rtl/three_bit_count_pwm.sv
// Resamples a free-running 3-bit up-counter, flags sequence breaks, counts
// wrap-arounds and drives a PWM whose duty is updated only at period boundaries.
module three_bit_count_pwm #(
    parameter int unsigned WRAP_W   = 8,
    parameter logic [3:0]  DUTY_RST = 4'd4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        count_in,
    input  logic [3:0]        duty_in,
    input  logic              duty_valid,
    output logic              duty_ready,
    input  logic              err_clr,
    output logic              pwm_out,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              step_err
);

    logic [2:0] cnt_s;
    logic [2:0] cnt_p;
    logic [1:0] arm;
    logic       pending;
    logic [3:0] pend_duty;
    logic [3:0] active_duty;

    logic       armed;
    logic       step_bad;
    logic       wrap_ev;
    logic       apply;
    logic       accept;
    logic [3:0] next_duty;

    always_comb begin
        armed     = (arm == 2'd2);
        step_bad  = armed && (cnt_s != (cnt_p + 3'd1));
        wrap_ev   = armed && (cnt_p == 3'd7) && (cnt_s == 3'd0);
        apply     = wrap_ev && pending;
        accept    = duty_valid && !pending;
        next_duty = apply ? pend_duty : active_duty;
    end

    assign duty_ready = ~pending;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_s       <= '0;
            cnt_p       <= '0;
            arm         <= '0;
            pending     <= 1'b0;
            pend_duty   <= '0;
            active_duty <= DUTY_RST;
            pwm_out     <= 1'b0;
            wrap_pulse  <= 1'b0;
            wrap_cnt    <= '0;
            step_err    <= 1'b0;
        end else begin
            cnt_s <= count_in;
            cnt_p <= cnt_s;
            if (arm != 2'd2) begin
                arm <= arm + 2'd1;
            end

            wrap_pulse <= wrap_ev;
            if (wrap_ev) begin
                wrap_cnt <= wrap_cnt + {{(WRAP_W-1){1'b0}}, 1'b1};
            end

            // A new error wins over a simultaneous clear.
            if (step_bad) begin
                step_err <= 1'b1;
            end else if (err_clr) begin
                step_err <= 1'b0;
            end

            // accept and apply are mutually exclusive: apply needs pending, accept needs !pending.
            if (apply) begin
                active_duty <= pend_duty;
                pending     <= 1'b0;
            end else if (accept) begin
                pending   <= 1'b1;
                pend_duty <= duty_in;
            end

            pwm_out <= ({1'b0, cnt_s} < next_duty);
        end
    end

endmodule
